led_packet_parser: RTL
======================

# led_packet_parser

Byte-stream parser between the UART receiver and the LED memory write port. It consumes bytes decoded by `uart` and assembles framed packets that each carry a start address, an LED count and GRB colour triplets. For each completed triplet it issues one write into the LED memory, and it validates every packet with an XOR checksum and an inter-byte timeout.

## Interface
Parameters:
- `SYNC_BYTE`, default 8'hA5: packet start marker.
- `ADDR_WIDTH`, default 9: LED memory address width.
- `TIMEOUT_CYCLES`, default 120000: maximum `clock_12mhz` cycles allowed between bytes inside a packet (10 ms).

Ports:
- `clock_12mhz`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `rx_data`  in  8  received byte; valid when `rx_data_ready` is high.
- `rx_data_ready`  in  1  one-cycle strobe per byte, already synchronous to `clock_12mhz`.
- `slave_select`  in  1  high means selected; low aborts any packet in progress.
- `perform_write`  out  1  one-cycle write strobe to memory.
- `write_address`  out  ADDR_WIDTH  memory address for the write.
- `write_data`  out  24  colour word {G,R,B}.
- `frame_done`  out  1  one-cycle pulse when a packet passes its checksum.
- `busy`  out  1  high whenever the state is not IDLE.
- `error_count`  out  8  saturating count of bad packets.

## Operation
- Packet format: SYNC, ADDR_HI (bit0 = address[8]; bits 7:1 ignored), ADDR_LO, COUNT, then N×{G,R,B}, then CHK.
  - N = COUNT; COUNT = 0 means N = 256.
  - CHK = XOR of every byte from ADDR_HI through the last B. SYNC is excluded.
- States and transitions:
  - IDLE → ADDR_HI on a byte equal to SYNC_BYTE while `slave_select`=1. Any other byte is ignored silently.
  - ADDR_HI → ADDR_LO → COUNT → DATA, one accepted byte per step.
  - DATA: a 2-bit byte index counts 0,1,2.
    - Byte 0 latches G, byte 1 latches R.
    - Byte 2 latches B and issues the write. It then increments the address and decrements the remaining-LED counter.
    - When the remaining count reaches 0 the state moves to CHECK.
  - CHECK: compare the byte with the running XOR.
    - Match: pulse `frame_done`.
    - Mismatch: increment `error_count`.
    - Either outcome returns to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: a start of 511 with N=2 writes addresses 511 then 0.
- Writes are issued as data arrives and are never rolled back. The checksum result affects only `frame_done` and `error_count`.
- SYNC_BYTE appearing inside a packet is treated as ordinary data. The parser does not resynchronise mid-packet.
- Abort conditions apply in any non-IDLE state:
  - Abort on `slave_select`=0, or on the timeout counter reaching TIMEOUT_CYCLES.
  - An abort returns to IDLE, increments `error_count` and issues no write for a partial triplet.
  - An abort that coincides with the third byte of a triplet takes priority, so no write is issued.
- `error_count` saturates at 255.
- Reset mid-packet drops the packet immediately and does not count as an error.

## Timing
- Reset values: state IDLE, `perform_write`=0, `write_address`=0, `write_data`=0, `frame_done`=0, `busy`=0, `error_count`=0.
- Bytes are accepted only on cycles where `rx_data_ready`=1. Back-to-back strobes on consecutive cycles must be accepted without loss.
- `perform_write` goes high the cycle after the strobe of the B byte. In that same cycle `write_address` and `write_data` are valid, and both hold until the next write.
- `frame_done` goes high the cycle after the strobe of a matching CHK byte, for exactly one cycle.
- `busy` rises the cycle after SYNC is accepted and falls the cycle after CHK is accepted or an abort occurs.
- Timeout counter behaviour:
  - Clears on every accepted byte and whenever the state is IDLE.
  - The abort fires in the cycle after the count reaches TIMEOUT_CYCLES.
- There is no backpressure. Memory accepts a write on every `perform_write` strobe.

## Test plan
- Valid packet: A5 00 05 02, 11 22 33, 44 55 66, CHK=00^05^02^11^22^33^44^55^66 → writes (5,112233h) then (6,445566h), one `frame_done` pulse, `error_count`=0.
- Address wrap: A5 01 FF 02 with two triplets and a correct CHK → writes at addresses 511 and 0.
- Bad checksum: valid packet with CHK^01 → both writes still occur, no `frame_done`, `error_count`=1, parser then accepts the next good packet.
- Abort cases:
  - `slave_select` dropped after two data bytes → no write, `busy`=0 next cycle, `error_count`+1.
  - Stall of TIMEOUT_CYCLES with TIMEOUT_CYCLES=100 → same response.
- COUNT=0 → exactly 256 writes before CHECK. 300 consecutive faulty packets → `error_count` holds at 255.
- Reset asserted mid-DATA → all outputs return to reset values next cycle and `error_count` is unchanged at 0. Garbage bytes before SYNC are ignored.

Source files
------------

// File: rtl/led_packet_parser.sv
// Framed byte-stream parser: SYNC, address, LED count, GRB triplets, XOR checksum.
// Each completed triplet becomes one LED memory write; bad packets and aborts are counted.
module led_packet_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic                  clock_12mhz,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_ready,
  input  logic                  slave_select,
  output logic                  perform_write,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [23:0]           write_data,
  output logic                  frame_done,
  output logic                  busy,
  output logic [7:0]            error_count
);

  localparam int unsigned TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_HI = 3'd1;
  localparam logic [2:0] ST_ADDR_LO = 3'd2;
  localparam logic [2:0] ST_COUNT   = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_CHECK   = 3'd5;

  logic [2:0]             state;
  logic [2:0]             next_state;
  logic                   addr_hi_bit;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic [8:0]             remaining;
  logic [1:0]             byte_idx;
  logic [7:0]             green;
  logic [7:0]             red;
  logic [7:0]             running_xor;
  logic [TIMER_WIDTH-1:0] timer;

  logic abort;
  logic accept;
  logic chk_match;
  logic bad_packet;

  // Abort outranks a byte arriving in the same cycle, so a coinciding B byte never writes.
  assign abort      = (state != ST_IDLE) &&
                      (!slave_select || (timer == TIMER_WIDTH'(TIMEOUT_CYCLES)));
  assign accept     = rx_data_ready && !abort;
  assign chk_match  = (rx_data == running_xor);
  assign bad_packet = abort || (accept && (state == ST_CHECK) && !chk_match);
  assign busy       = (state != ST_IDLE);

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = ST_IDLE;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          if (slave_select && (rx_data == SYNC_BYTE)) begin
            next_state = ST_ADDR_HI;
          end
        end
        ST_ADDR_HI: next_state = ST_ADDR_LO;
        ST_ADDR_LO: next_state = ST_COUNT;
        ST_COUNT:   next_state = ST_DATA;
        ST_DATA: begin
          if ((byte_idx == 2'd2) && (remaining == 9'd1)) begin
            next_state = ST_CHECK;
          end
        end
        ST_CHECK:   next_state = ST_IDLE;
        default:    next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock_12mhz) begin
    if (reset || (state == ST_IDLE) || accept || abort) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_WIDTH'(1);
    end
  end

  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      perform_write <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      frame_done    <= 1'b0;
      addr_hi_bit   <= 1'b0;
      cur_addr      <= '0;
      remaining     <= '0;
      byte_idx      <= '0;
      green         <= '0;
      red           <= '0;
      running_xor   <= '0;
    end else begin
      perform_write <= 1'b0;
      frame_done    <= 1'b0;
      if (accept) begin
        case (state)
          ST_ADDR_HI: begin
            addr_hi_bit <= rx_data[0];
            running_xor <= rx_data;
          end
          ST_ADDR_LO: begin
            cur_addr    <= ADDR_WIDTH'({addr_hi_bit, rx_data});
            running_xor <= running_xor ^ rx_data;
          end
          ST_COUNT: begin
            remaining   <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            byte_idx    <= '0;
            running_xor <= running_xor ^ rx_data;
          end
          ST_DATA: begin
            running_xor <= running_xor ^ rx_data;
            case (byte_idx)
              2'd0: begin
                green    <= rx_data;
                byte_idx <= 2'd1;
              end
              2'd1: begin
                red      <= rx_data;
                byte_idx <= 2'd2;
              end
              default: begin
                perform_write <= 1'b1;
                write_address <= cur_addr;
                write_data    <= {green, red, rx_data};
                cur_addr      <= cur_addr + ADDR_WIDTH'(1);
                remaining     <= remaining - 9'd1;
                byte_idx      <= 2'd0;
              end
            endcase
          end
          ST_CHECK: frame_done <= chk_match;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      error_count <= '0;
    end else if (bad_packet && (error_count != 8'hFF)) begin
      error_count <= error_count + 8'd1;
    end
  end

endmodule
